// File: rtl/mem_port_arbiter.sv
// Two-requester (data / instruction) arbiter onto a single memory port.
// One outstanding transaction at a time, round-robin on contention, response timeout.
module mem_port_arbiter #(
  parameter int TIMEOUT = 16,
  parameter bit RR_INIT = 1'b0
) (
  input  logic        clk_i,
  input  logic        rst_i,

  input  logic        d_req_i,
  input  logic [31:0] d_addr_i,
  input  logic        d_we_i,
  input  logic [3:0]  d_be_i,
  input  logic [31:0] d_wdata_i,
  output logic        d_gnt_o,
  output logic        d_rvalid_o,
  output logic [31:0] d_rdata_o,

  input  logic        i_req_i,
  input  logic [31:0] i_addr_i,
  output logic        i_gnt_o,
  output logic        i_rvalid_o,
  output logic [31:0] i_rdata_o,

  output logic        mem_req_o,
  output logic [31:0] mem_addr_o,
  output logic        mem_we_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_gnt_i,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i,

  output logic        err_o
);

  localparam int CW = $clog2(TIMEOUT + 1);
  // The timeout fires in the WAIT cycle whose increment would bring the count to TIMEOUT.
  localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT - 1);
  localparam logic [31:0]   TMO_DATA = 32'hDEAD_BEEF;

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic          owner;   // 0 = data, 1 = instr
  logic          rr;      // requester holding priority on contention
  logic          err;

  logic        sel_i;
  logic        grant;
  logic        waiting;
  logic        resp;
  logic        tmo;
  logic        done;
  logic [31:0] rdata;

  always_comb begin
    sel_i       = i_req_i & (~d_req_i | rr);
    mem_req_o   = (state == S_IDLE) & ~rst_i & (d_req_i | i_req_i);
    mem_addr_o  = sel_i ? i_addr_i : d_addr_i;
    mem_we_o    = sel_i ? 1'b0     : d_we_i;
    mem_be_o    = sel_i ? 4'hF     : d_be_i;
    mem_wdata_o = sel_i ? 32'h0    : d_wdata_i;
    grant       = mem_req_o & mem_gnt_i;
    d_gnt_o     = grant & ~sel_i;
    i_gnt_o     = grant & sel_i;

    waiting     = (state == S_WAIT) & ~rst_i;
    resp        = waiting & mem_rvalid_i;
    tmo         = waiting & ~mem_rvalid_i & (cnt == TMO_LAST);
    done        = resp | tmo;
    rdata       = resp ? mem_rdata_i : TMO_DATA;
    d_rvalid_o  = done & ~owner;
    i_rvalid_o  = done & owner;
    d_rdata_o   = d_rvalid_o ? rdata : 32'h0;
    i_rdata_o   = i_rvalid_o ? rdata : 32'h0;
    err_o       = err;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= S_IDLE;
      cnt   <= '0;
      owner <= 1'b0;
      rr    <= RR_INIT;
      err   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (grant) begin
            state <= S_WAIT;
            owner <= sel_i;
            rr    <= ~sel_i;
            cnt   <= '0;
          end
        end
        S_WAIT: begin
          if (resp) begin
            state <= S_IDLE;
          end else if (tmo) begin
            state <= S_IDLE;
            err   <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed testbench for mem_port_arbiter: inputs driven 1 time unit after the
// rising edge, combinational outputs sampled on the falling edge.
module tb_mem_port_arbiter;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        d_req_i;
  logic [31:0] d_addr_i;
  logic        d_we_i;
  logic [3:0]  d_be_i;
  logic [31:0] d_wdata_i;
  logic        d_gnt_o;
  logic        d_rvalid_o;
  logic [31:0] d_rdata_o;
  logic        i_req_i;
  logic [31:0] i_addr_i;
  logic        i_gnt_o;
  logic        i_rvalid_o;
  logic [31:0] i_rdata_o;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic        mem_we_o;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_wdata_o;
  logic        mem_gnt_i;
  logic        mem_rvalid_i;
  logic [31:0] mem_rdata_i;
  logic        err_o;

  int vecs = 0;
  int errs = 0;

  mem_port_arbiter #(.TIMEOUT(16), .RR_INIT(1'b0)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .d_req_i(d_req_i), .d_addr_i(d_addr_i), .d_we_i(d_we_i), .d_be_i(d_be_i),
    .d_wdata_i(d_wdata_i), .d_gnt_o(d_gnt_o), .d_rvalid_o(d_rvalid_o), .d_rdata_o(d_rdata_o),
    .i_req_i(i_req_i), .i_addr_i(i_addr_i), .i_gnt_o(i_gnt_o), .i_rvalid_o(i_rvalid_o),
    .i_rdata_o(i_rdata_o),
    .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o),
    .mem_wdata_o(mem_wdata_o), .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i),
    .mem_rdata_i(mem_rdata_i), .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  task automatic quiet();
    d_req_i = 0; d_addr_i = 0; d_we_i = 0; d_be_i = 0; d_wdata_i = 0;
    i_req_i = 0; i_addr_i = 0;
    mem_gnt_i = 0; mem_rvalid_i = 0; mem_rdata_i = 0;
  endtask

  task automatic test_reset();
    rst_i = 1; quiet();
    d_req_i = 1; i_req_i = 1; mem_gnt_i = 1; mem_rvalid_i = 1; mem_rdata_i = 32'h1111_2222;
    @(negedge clk_i);
    vecs++;
    if ({d_gnt_o, i_gnt_o, d_rvalid_o, i_rvalid_o, mem_req_o, err_o} !== 6'b0) begin
      errs++;
      $display("FAIL reset_flags got %b want 000000",
               {d_gnt_o, i_gnt_o, d_rvalid_o, i_rvalid_o, mem_req_o, err_o});
    end
    vecs++;
    if ({d_rdata_o, i_rdata_o} !== 64'h0) begin
      errs++;
      $display("FAIL reset_rdata got %h want 0", {d_rdata_o, i_rdata_o});
    end
    cyc(); quiet(); rst_i = 0;
  endtask

  task automatic test_data_write();
    cyc();
    d_req_i = 1; d_addr_i = 32'h100; d_we_i = 1; d_be_i = 4'h3; d_wdata_i = 32'h1234;
    mem_gnt_i = 1;
    @(negedge clk_i);
    vecs++;
    if ({mem_req_o, mem_addr_o, mem_we_o, mem_be_o, mem_wdata_o} !== {1'b1, 32'h100, 1'b1, 4'h3, 32'h1234}) begin
      errs++;
      $display("FAIL dw_mem_fields got %h want %h",
               {mem_req_o, mem_addr_o, mem_we_o, mem_be_o, mem_wdata_o},
               {1'b1, 32'h100, 1'b1, 4'h3, 32'h1234});
    end
    vecs++;
    if ({d_gnt_o, i_gnt_o, d_rvalid_o} !== 3'b100) begin
      errs++;
      $display("FAIL dw_grant got %b want 100", {d_gnt_o, i_gnt_o, d_rvalid_o});
    end
    cyc();
    quiet(); mem_rvalid_i = 1; mem_rdata_i = 32'h0000_55AA;
    @(negedge clk_i);
    vecs++;
    if ({d_gnt_o, i_gnt_o, mem_req_o, d_rvalid_o, i_rvalid_o, d_rdata_o} !== {5'b00010, 32'h55AA}) begin
      errs++;
      $display("FAIL dw_response got %h want %h",
               {d_gnt_o, i_gnt_o, mem_req_o, d_rvalid_o, i_rvalid_o, d_rdata_o}, {5'b00010, 32'h55AA});
    end
    cyc();
    quiet();
    @(negedge clk_i);
    vecs++;
    if ({d_rvalid_o, err_o, d_rdata_o} !== 34'h0) begin
      errs++;
      $display("FAIL dw_after got %h want 0", {d_rvalid_o, err_o, d_rdata_o});
    end
  endtask

  task automatic test_instr_read();
    cyc();
    quiet(); i_req_i = 1; i_addr_i = 32'h80; d_addr_i = 32'hFFFF_0000; d_we_i = 1; d_be_i = 4'h1;
    mem_gnt_i = 1;
    @(negedge clk_i);
    vecs++;
    if ({mem_req_o, mem_addr_o, mem_we_o, mem_be_o, i_gnt_o, d_gnt_o} !== {1'b1, 32'h80, 1'b0, 4'hF, 2'b10}) begin
      errs++;
      $display("FAIL ir_request got %h want %h",
               {mem_req_o, mem_addr_o, mem_we_o, mem_be_o, i_gnt_o, d_gnt_o},
               {1'b1, 32'h80, 1'b0, 4'hF, 2'b10});
    end
    cyc();
    quiet(); mem_rvalid_i = 1; mem_rdata_i = 32'hCAFE_F00D;
    @(negedge clk_i);
    vecs++;
    if ({i_rvalid_o, i_rdata_o, d_rvalid_o, d_rdata_o} !== {1'b1, 32'hCAFE_F00D, 1'b0, 32'h0}) begin
      errs++;
      $display("FAIL ir_response got %h want %h",
               {i_rvalid_o, i_rdata_o, d_rvalid_o, d_rdata_o}, {1'b1, 32'hCAFE_F00D, 1'b0, 32'h0});
    end
  endtask

  task automatic test_boundary();
    cyc();
    quiet(); d_req_i = 1; d_addr_i = 32'h40; mem_gnt_i = 1;
    @(negedge clk_i);
    vecs++;
    if (d_gnt_o !== 1'b1) begin
      errs++;
      $display("FAIL bnd_grant got %b want 1", d_gnt_o);
    end
    for (int c = 1; c <= 15; c++) begin
      cyc(); quiet();
      @(negedge clk_i);
      vecs++;
      if ({d_rvalid_o, i_rvalid_o} !== 2'b00) begin
        errs++;
        $display("FAIL bnd_wait cycle %0d got %b want 00", c, {d_rvalid_o, i_rvalid_o});
      end
    end
    cyc();
    quiet(); mem_rvalid_i = 1; mem_rdata_i = 32'h600D_DA7A;
    @(negedge clk_i);
    vecs++;
    if ({d_rvalid_o, d_rdata_o} !== {1'b1, 32'h600D_DA7A}) begin
      errs++;
      $display("FAIL bnd_response got %h want %h", {d_rvalid_o, d_rdata_o}, {1'b1, 32'h600D_DA7A});
    end
    cyc(); quiet();
    @(negedge clk_i);
    vecs++;
    if ({err_o, d_rvalid_o} !== 2'b00) begin
      errs++;
      $display("FAIL bnd_err got %b want 00", {err_o, d_rvalid_o});
    end
  endtask

  task automatic test_timeout();
    cyc();
    quiet(); d_req_i = 1; d_addr_i = 32'h44; mem_gnt_i = 1;
    @(negedge clk_i);
    vecs++;
    if (d_gnt_o !== 1'b1) begin
      errs++;
      $display("FAIL tmo_grant got %b want 1", d_gnt_o);
    end
    for (int c = 1; c <= 15; c++) begin
      cyc(); quiet();
      @(negedge clk_i);
      vecs++;
      if ({d_rvalid_o, i_rvalid_o, err_o} !== 3'b000) begin
        errs++;
        $display("FAIL tmo_wait cycle %0d got %b want 000", c, {d_rvalid_o, i_rvalid_o, err_o});
      end
    end
    cyc(); quiet();
    @(negedge clk_i);
    vecs++;
    if ({d_rvalid_o, d_rdata_o, i_rvalid_o} !== {1'b1, 32'hDEAD_BEEF, 1'b0}) begin
      errs++;
      $display("FAIL tmo_response got %h want %h", {d_rvalid_o, d_rdata_o, i_rvalid_o},
               {1'b1, 32'hDEAD_BEEF, 1'b0});
    end
    // Next cycle: back in IDLE (a fresh request is presented) with the error flag raised.
    cyc();
    quiet(); i_req_i = 1; i_addr_i = 32'h90; mem_gnt_i = 1;
    @(negedge clk_i);
    vecs++;
    if ({err_o, mem_req_o, i_gnt_o, d_rvalid_o} !== 4'b1110) begin
      errs++;
      $display("FAIL tmo_after got %b want 1110", {err_o, mem_req_o, i_gnt_o, d_rvalid_o});
    end
    cyc();
    quiet(); mem_rvalid_i = 1; mem_rdata_i = 32'h1234_5678;
    @(negedge clk_i);
    vecs++;
    if ({err_o, i_rvalid_o, i_rdata_o} !== {2'b11, 32'h1234_5678}) begin
      errs++;
      $display("FAIL tmo_sticky got %h want %h", {err_o, i_rvalid_o, i_rdata_o}, {2'b11, 32'h1234_5678});
    end
  endtask

  task automatic test_reset_in_wait();
    cyc();
    quiet(); d_req_i = 1; d_addr_i = 32'h500; mem_gnt_i = 1;
    @(negedge clk_i);
    vecs++;
    if (d_gnt_o !== 1'b1) begin
      errs++;
      $display("FAIL rw_grant got %b want 1", d_gnt_o);
    end
    cyc();
    quiet(); rst_i = 1; mem_rvalid_i = 1; mem_rdata_i = 32'hBAD0_0001;
    @(negedge clk_i);
    vecs++;
    if ({d_rvalid_o, i_rvalid_o, d_rdata_o, err_o} !== 35'h0) begin
      errs++;
      $display("FAIL rw_during got %h want 0", {d_rvalid_o, i_rvalid_o, d_rdata_o, err_o});
    end
    cyc();
    rst_i = 0; quiet(); mem_rvalid_i = 1; mem_rdata_i = 32'hBAD0_0002;
    @(negedge clk_i);
    vecs++;
    if ({d_rvalid_o, i_rvalid_o, d_rdata_o, i_rdata_o, err_o} !== 67'h0) begin
      errs++;
      $display("FAIL rw_stray got %h want 0", {d_rvalid_o, i_rvalid_o, d_rdata_o, i_rdata_o, err_o});
    end
    // Pointer was moved to instr by the abandoned data grant; reset must restore data priority.
    cyc();
    quiet(); d_req_i = 1; i_req_i = 1; d_addr_i = 32'h200; i_addr_i = 32'h300; mem_gnt_i = 1;
    @(negedge clk_i);
    vecs++;
    if ({mem_req_o, d_gnt_o, i_gnt_o, mem_addr_o} !== {3'b110, 32'h200}) begin
      errs++;
      $display("FAIL rw_pointer got %h want %h", {mem_req_o, d_gnt_o, i_gnt_o, mem_addr_o}, {3'b110, 32'h200});
    end
    cyc();
    quiet(); mem_rvalid_i = 1; mem_rdata_i = 32'h0;
    cyc(); quiet();
  endtask

  task automatic test_contention();
    logic        exp_i;
    logic [31:0] exp_addr;
    cyc();
    quiet(); rst_i = 1;
    cyc();
    rst_i = 0;
    for (int k = 0; k < 8; k++) begin
      exp_i    = k[0];
      exp_addr = exp_i ? 32'h300 : 32'h200;
      cyc();
      quiet(); d_req_i = 1; i_req_i = 1; d_addr_i = 32'h200; i_addr_i = 32'h300; mem_gnt_i = 1;
      @(negedge clk_i);
      vecs++;
      if ({d_gnt_o, i_gnt_o, mem_addr_o} !== {~exp_i, exp_i, exp_addr}) begin
        errs++;
        $display("FAIL rr_grant txn %0d got %h want %h", k, {d_gnt_o, i_gnt_o, mem_addr_o},
                 {~exp_i, exp_i, exp_addr});
      end
      cyc();
      mem_rvalid_i = 1; mem_rdata_i = 32'hA000_0000 + k;
      @(negedge clk_i);
      vecs++;
      if ({mem_req_o, d_gnt_o, i_gnt_o, d_rvalid_o, i_rvalid_o} !== {3'b000, ~exp_i, exp_i} ||
          (exp_i ? i_rdata_o : d_rdata_o) !== 32'hA000_0000 + k ||
          (exp_i ? d_rdata_o : i_rdata_o) !== 32'h0) begin
        errs++;
        $display("FAIL rr_response txn %0d got %b d=%h i=%h want owner_i=%0d data=%h", k,
                 {mem_req_o, d_gnt_o, i_gnt_o, d_rvalid_o, i_rvalid_o}, d_rdata_o, i_rdata_o,
                 exp_i, 32'hA000_0000 + k);
      end
    end
    cyc(); quiet();
  endtask

  initial begin
    test_reset();
    test_data_write();
    test_instr_read();
    test_boundary();
    test_timeout();
    test_reset_in_wait();
    test_contention();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
